// File: rtl/axis_array_packet_sequence_checker_pkg.sv
// Shared definitions for the multi-channel AXI-Stream test-packet checker:
// header layout, channel FSM states and small byte-level helpers.
package axis_seq_chk_pkg;

  // Byte offsets of the self-describing header inside every test packet
  localparam int SEQ_OFFSET     = 0;
  localparam int BLEN_OFFSET    = 4;
  localparam int PAYLOAD_OFFSET = 6;

  // Widest tkeep the popcount helper accepts (DATA_BYTES up to 64)
  localparam int MAX_KEEP_BITS  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BODY = 2'd1,
    EVAL = 2'd2
  } chk_state_t;

  // Payload byte at absolute packet index k (only the low 8 bits of k matter)
  function automatic logic [7:0] expected_byte(input logic [7:0] seq8, input logic [7:0] k);
    return seq8 + k;
  endfunction

  // Number of enabled bytes in a beat
  function automatic logic [7:0] popcount_keep(input logic [MAX_KEEP_BITS-1:0] keep);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < MAX_KEEP_BITS; i++) begin
      n = n + {7'd0, keep[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/axis_array_packet_sequence_checker_if.sv
// Bundled AXI-Stream sink bus for all checker channels; channel i occupies
// slice i of every field.
interface axis_array_packet_sequence_checker_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_BYTES   = 8
);

  logic [NUM_CHANNELS*DATA_BYTES*8-1:0] tdata;
  logic [NUM_CHANNELS*DATA_BYTES-1:0]   tkeep;
  logic [NUM_CHANNELS-1:0]              tvalid;
  logic [NUM_CHANNELS-1:0]              tlast;
  logic [NUM_CHANNELS-1:0]              tready;

  modport master (
    output tdata, tkeep, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast,
    output tready
  );

endinterface

// File: rtl/axis_array_packet_sequence_checker_chan.sv
// One checker channel: parses and verifies a single AXI-Stream of test
// packets, keeps saturating statistics and optionally throttles tready
// with a free-running LFSR.
module axis_packet_sequence_checker_chan
  import axis_seq_chk_pkg::*;
#(
  parameter int          DATA_BYTES      = 8,
  parameter int          MIN_BLEN        = 64,
  parameter int          MAX_BLEN        = 1500,
  parameter int          CNT_WIDTH       = 32,
  parameter int          BACKPRESSURE_EN = 0,
  parameter logic [31:0] LFSR_SEED       = 32'hACE1_2024
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic [DATA_BYTES*8-1:0] tdata_i,
  input  logic [DATA_BYTES-1:0]   tkeep_i,
  input  logic                    tvalid_i,
  input  logic                    tlast_i,
  output logic                    tready_o,
  input  logic [7:0]              bp_ready_pct_i,
  input  logic                    cnt_clear_i,
  output logic [CNT_WIDTH-1:0]    good_cnt_o,
  output logic [CNT_WIDTH-1:0]    seq_err_cnt_o,
  output logic [CNT_WIDTH-1:0]    len_err_cnt_o,
  output logic [CNT_WIDTH-1:0]    data_err_cnt_o,
  output logic                    err_sticky_o
);

  localparam logic [DATA_BYTES-1:0] KEEP_ALL  = '1;
  localparam logic [DATA_BYTES-1:0] KEEP_ONE  = DATA_BYTES'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [31:0]           SEED_SAFE = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
  localparam logic [31:0]           LFSR_TAPS = 32'h8020_0003;

  chk_state_t state_q, state_d;

  logic                 readyEn_q;
  logic [31:0]          lfsr_q, lfsr_d;
  logic [31:0]          seq_q;
  logic [31:0]          expSeq_q;
  logic [15:0]          hdrBlen_q;
  logic [16:0]          byteCnt_q, byteCnt_d;
  logic                 seqLocked_q;
  logic                 keepErr_q;
  logic                 dataErr_q;
  logic                 errSticky_q;
  logic [CNT_WIDTH-1:0] goodCnt_q, seqErrCnt_q, lenErrCnt_q, dataErrCnt_q;

  logic                     beat, bpOk, evalActive;
  logic                     lenErr, seqErr, anyErr;
  logic                     laneErr, keepBad, keepContig;
  logic [31:0]              seqNew;
  logic [15:0]              blenNew;
  logic [7:0]               beatBytes;
  logic [17:0]              cntSum;
  logic [MAX_KEEP_BITS-1:0] keepWide;

  function automatic logic [CNT_WIDTH-1:0] satInc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  assign beat = tvalid_i & tready_o;

  // State register for the per-channel packet FSM
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: header beat, body beats, then one evaluation cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (beat) state_d = tlast_i ? EVAL : BODY;
      BODY:    if (beat && tlast_i) state_d = EVAL;
      EVAL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: tready gating and the evaluation strobe
  always_comb begin
    bpOk       = (BACKPRESSURE_EN == 0) || (bp_ready_pct_i == 8'hFF) ||
                 (lfsr_q[7:0] < bp_ready_pct_i);
    tready_o   = readyEn_q && bpOk && (state_q != EVAL);
    evalActive = (state_q == EVAL);
  end

  // Header fields as they appear on the first beat, big-endian on the wire
  always_comb begin
    seqNew  = {tdata_i[8*SEQ_OFFSET +: 8],       tdata_i[8*(SEQ_OFFSET+1) +: 8],
               tdata_i[8*(SEQ_OFFSET+2) +: 8],   tdata_i[8*(SEQ_OFFSET+3) +: 8]};
    blenNew = {tdata_i[8*BLEN_OFFSET +: 8],      tdata_i[8*(BLEN_OFFSET+1) +: 8]};
  end

  // Per-lane payload comparison; header lanes are skipped on the first beat
  always_comb begin
    laneErr = 1'b0;
    for (int j = 0; j < DATA_BYTES; j++) begin
      if (state_q == IDLE) begin
        if ((j >= PAYLOAD_OFFSET) && tkeep_i[j] &&
            (tdata_i[8*j +: 8] != expected_byte(seqNew[7:0], 8'(j)))) begin
          laneErr = 1'b1;
        end
      end else if (tkeep_i[j] &&
                   (tdata_i[8*j +: 8] != expected_byte(seq_q[7:0], byteCnt_q[7:0] + 8'(j)))) begin
        laneErr = 1'b1;
      end
    end
  end

  // Byte counting (17-bit saturating) and tkeep legality of the current beat
  always_comb begin
    keepWide                 = '0;
    keepWide[DATA_BYTES-1:0] = tkeep_i;
    beatBytes  = popcount_keep(keepWide);
    cntSum     = ((state_q == IDLE) ? 18'd0 : {1'b0, byteCnt_q}) + {10'd0, beatBytes};
    byteCnt_d  = cntSum[17] ? '1 : cntSum[16:0];
    keepContig = tkeep_i[0] && ((tkeep_i & (tkeep_i + KEEP_ONE)) == '0);
    keepBad    = tlast_i ? !keepContig : (tkeep_i != KEEP_ALL);
  end

  // Verdict for the packet being evaluated
  always_comb begin
    lenErr = (byteCnt_q != {1'b0, hdrBlen_q}) ||
             (byteCnt_q < 17'(MIN_BLEN)) ||
             (byteCnt_q > 17'(MAX_BLEN)) ||
             keepErr_q;
    seqErr = seqLocked_q && (seq_q != expSeq_q);
    anyErr = lenErr || seqErr || dataErr_q;
  end

  // Galois LFSR next value
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0);
  end

  // Ready enable and backpressure LFSR run every cycle once out of reset
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      readyEn_q <= 1'b0;
      lfsr_q    <= SEED_SAFE;
    end else begin
      readyEn_q <= 1'b1;
      lfsr_q    <= lfsr_d;
    end
  end

  // Capture header and accumulate per-packet length/keep/payload status
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      seq_q     <= '0;
      hdrBlen_q <= '0;
      byteCnt_q <= '0;
      keepErr_q <= 1'b0;
      dataErr_q <= 1'b0;
    end else if (beat) begin
      if (state_q == IDLE) begin
        seq_q     <= seqNew;
        hdrBlen_q <= blenNew;
      end
      byteCnt_q <= byteCnt_d;
      keepErr_q <= ((state_q == IDLE) ? 1'b0 : keepErr_q) | keepBad;
      dataErr_q <= ((state_q == IDLE) ? 1'b0 : dataErr_q) | laneErr;
    end
  end

  // Statistics, sequence tracking and sticky error; a clear beats an increment
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      expSeq_q     <= '0;
      seqLocked_q  <= 1'b0;
      errSticky_q  <= 1'b0;
      goodCnt_q    <= '0;
      seqErrCnt_q  <= '0;
      lenErrCnt_q  <= '0;
      dataErrCnt_q <= '0;
    end else begin
      if (evalActive) begin
        expSeq_q <= seq_q + 32'd1;
      end
      if (cnt_clear_i) begin
        seqLocked_q  <= 1'b0;
        errSticky_q  <= 1'b0;
        goodCnt_q    <= '0;
        seqErrCnt_q  <= '0;
        lenErrCnt_q  <= '0;
        dataErrCnt_q <= '0;
      end else if (evalActive) begin
        seqLocked_q <= 1'b1;
        if (seqErr)    seqErrCnt_q  <= satInc(seqErrCnt_q);
        if (lenErr)    lenErrCnt_q  <= satInc(lenErrCnt_q);
        if (dataErr_q) dataErrCnt_q <= satInc(dataErrCnt_q);
        if (!anyErr)   goodCnt_q    <= satInc(goodCnt_q);
        if (anyErr)    errSticky_q  <= 1'b1;
      end
    end
  end

  assign good_cnt_o     = goodCnt_q;
  assign seq_err_cnt_o  = seqErrCnt_q;
  assign len_err_cnt_o  = lenErrCnt_q;
  assign data_err_cnt_o = dataErrCnt_q;
  assign err_sticky_o   = errSticky_q;

endmodule

// File: rtl/axis_array_packet_sequence_checker.sv
// Multi-channel AXI-Stream test-packet checker: one independent checker
// per channel, results flattened onto per-channel counter buses.
module axis_array_packet_sequence_checker
  import axis_seq_chk_pkg::*;
#(
  parameter int          NUM_CHANNELS    = 4,
  parameter int          DATA_BYTES      = 8,
  parameter int          MIN_BLEN        = 64,
  parameter int          MAX_BLEN        = 1500,
  parameter int          CNT_WIDTH       = 32,
  parameter int          BACKPRESSURE_EN = 0,
  parameter logic [31:0] LFSR_SEED       = 32'hACE1_2024
) (
  input  logic                              clk,
  input  logic                              aresetn,
  axis_array_packet_sequence_checker_if.slave s_axis,
  input  logic [7:0]                        bp_ready_pct,
  input  logic [NUM_CHANNELS-1:0]           cnt_clear,
  output logic [NUM_CHANNELS*CNT_WIDTH-1:0] good_pkt_cnt,
  output logic [NUM_CHANNELS*CNT_WIDTH-1:0] seq_err_cnt,
  output logic [NUM_CHANNELS*CNT_WIDTH-1:0] len_err_cnt,
  output logic [NUM_CHANNELS*CNT_WIDTH-1:0] data_err_cnt,
  output logic [NUM_CHANNELS-1:0]           err_sticky
);

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
    axis_packet_sequence_checker_chan #(
      .DATA_BYTES      (DATA_BYTES),
      .MIN_BLEN        (MIN_BLEN),
      .MAX_BLEN        (MAX_BLEN),
      .CNT_WIDTH       (CNT_WIDTH),
      .BACKPRESSURE_EN (BACKPRESSURE_EN),
      .LFSR_SEED       (LFSR_SEED ^ 32'(i))
    ) u_chan (
      .clk            (clk),
      .aresetn        (aresetn),
      .tdata_i        (s_axis.tdata[i*DATA_BYTES*8 +: DATA_BYTES*8]),
      .tkeep_i        (s_axis.tkeep[i*DATA_BYTES +: DATA_BYTES]),
      .tvalid_i       (s_axis.tvalid[i]),
      .tlast_i        (s_axis.tlast[i]),
      .tready_o       (s_axis.tready[i]),
      .bp_ready_pct_i (bp_ready_pct),
      .cnt_clear_i    (cnt_clear[i]),
      .good_cnt_o     (good_pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH]),
      .seq_err_cnt_o  (seq_err_cnt[i*CNT_WIDTH +: CNT_WIDTH]),
      .len_err_cnt_o  (len_err_cnt[i*CNT_WIDTH +: CNT_WIDTH]),
      .data_err_cnt_o (data_err_cnt[i*CNT_WIDTH +: CNT_WIDTH]),
      .err_sticky_o   (err_sticky[i])
    );
  end

endmodule
